// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search for axis_rr_packet_arbiter.
// Optional feature macro used by the arbiter: AXIS_ARB_TID_EN.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int unsigned ARB_MAX_PORTS = 16;
  localparam int unsigned ARB_PICK_W    = 4;

  typedef struct packed {
    logic                  found;
    logic [ARB_PICK_W-1:0] idx;
  } rr_pick_t;

  // Rotate so last_grant+1 sits at bit 0, take the lowest set bit, then
  // rotate the winning position back into a port index.
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_PORTS-1:0] valid,
                                       input logic [ARB_PICK_W-1:0]    last_grant,
                                       input int unsigned              num_ports);
    logic [ARB_MAX_PORTS-1:0] rot;
    rr_pick_t                 res;
    int unsigned              j;
    int unsigned              k;
    rot = '0;
    res = '0;
    k   = 0;
    for (int unsigned i = 0; i < ARB_MAX_PORTS; i++) begin
      if (i < num_ports) begin
        j = 32'(last_grant) + 1 + i;
        if (j >= num_ports) j = j - num_ports;
        rot[i] = valid[j[ARB_PICK_W-1:0]];
      end
    end
    for (int unsigned i = ARB_MAX_PORTS; i > 0; i--) begin
      if ((i - 1 < num_ports) && rot[i-1]) begin
        res.found = 1'b1;
        k         = i - 1;
      end
    end
    j = 32'(last_grant) + 1 + k;
    if (j >= num_ports) j = j - num_ports;
    res.idx = j[ARB_PICK_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_if.sv
// Bundled source/sink AXI-Stream signals of axis_rr_packet_arbiter.
// m_axis_tid is present only when AXIS_ARB_TID_EN is defined.
interface axis_rr_packet_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4
);
  localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_W-1:0]     s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_W-1:0]               m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_tready;
`ifdef AXIS_ARB_TID_EN
  logic [IDX_W-1:0]                m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
`else
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
`endif
endinterface

// File: rtl/axis_arb_rr_picker.sv
// Combinational round-robin picker: first valid port after last_grant, wrapping.
module axis_arb_rr_picker
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic                 o_found,
  output logic [IDX_W-1:0]     o_idx
);

  logic [ARB_MAX_PORTS-1:0] w_valid_pad;
  logic [ARB_PICK_W-1:0]    w_last_pad;
  logic [ARB_PICK_W-1:0]    w_idx_full;

  // Widen to the package's fixed search width, search, narrow the result.
  always_comb begin
    w_valid_pad                  = '0;
    w_valid_pad[NUM_PORTS-1:0]   = i_valid;
    w_last_pad                   = '0;
    w_last_pad[IDX_W-1:0]        = i_last_grant;
    {o_found, w_idx_full}        = rr_pick(w_valid_pad, w_last_pad, NUM_PORTS);
    o_idx                        = IDX_W'(w_idx_full);
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter with a single registered output slot.
// Define AXIS_ARB_TID_EN to add m_axis_tid (grant index registered with each beat).
module axis_rr_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_PORTS  = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_PORTS),
  localparam int unsigned KEEP_W     = DATA_WIDTH / 8
) (
  input logic                     clk,
  input logic                     rst_n,
  axis_rr_packet_arbiter_if.slave bus
);

  arb_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_last_grant;
  logic                   w_pick_found;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [NUM_PORTS-1:0]   w_ready;
  logic                   w_slot_free;
  logic                   w_accept;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [KEEP_W-1:0]      w_sel_keep;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  r_tdata;
  logic [KEEP_W-1:0]      r_tkeep;
  logic                   r_tvalid;
  logic                   r_tlast;
`ifdef AXIS_ARB_TID_EN
  logic [IDX_W-1:0]       r_tid;
`endif

  axis_arb_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .i_valid      (bus.s_axis_tvalid),
    .i_last_grant (r_last_grant),
    .o_found      (w_pick_found),
    .o_idx        (w_pick_idx)
  );

  assign w_slot_free = bus.m_axis_tready | ~r_tvalid;

  // Select the granted port's beat.
  always_comb begin
    w_sel_data  = bus.s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_keep  = bus.s_axis_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
    w_sel_valid = bus.s_axis_tvalid[r_grant];
    w_sel_last  = bus.s_axis_tlast[r_grant];
  end

  // Next-state, grant capture and per-port ready.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ready     = '0;
    w_accept    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ARB_BUSY;
          w_grant_nxt = w_pick_idx;
        end
      end
      ARB_BUSY: begin
        w_ready[r_grant] = w_slot_free;
        w_accept         = w_sel_valid & w_slot_free;
        if (w_accept && w_sel_last) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (w_accept && w_sel_last) r_last_grant <= r_grant;
    end
  end

  // Output slot: load on accept, drop valid once drained with nothing new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
`ifdef AXIS_ARB_TID_EN
      r_tid    <= '0;
`endif
    end else if (w_accept) begin
      r_tdata  <= w_sel_data;
      r_tkeep  <= w_sel_keep;
      r_tvalid <= 1'b1;
      r_tlast  <= w_sel_last;
`ifdef AXIS_ARB_TID_EN
      r_tid    <= r_grant;
`endif
    end else if (w_slot_free) begin
      r_tvalid <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_ready;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tkeep  = r_tkeep;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
`ifdef AXIS_ARB_TID_EN
  assign bus.m_axis_tid    = r_tid;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Scoreboard bench for axis_rr_packet_arbiter (DATA_WIDTH=32, NUM_PORTS=4).
module tb_axis_rr_packet_arbiter;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            port;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_rr_packet_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  axis_rr_packet_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t         src_q[NP][$];
  beat_t         exp_q[$];
  logic [NP-1:0] hs_pend = '0;
  int            hs_cnt[NP];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            sb_on = 1'b1;
  bit            gap_on = 1'b0;
  int            cyc = 0;
  int            last_out_cyc = -1;
  bit            prev_last = 1'b0;
  bit            held = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        bus.s_axis_tvalid[p]           = 1'b1;
        bus.s_axis_tdata[p*DW +: DW]   = src_q[p][0].data;
        bus.s_axis_tkeep[p*KW +: KW]   = src_q[p][0].keep;
        bus.s_axis_tlast[p]            = src_q[p][0].last;
      end else begin
        bus.s_axis_tvalid[p]           = 1'b0;
        bus.s_axis_tdata[p*DW +: DW]   = '0;
        bus.s_axis_tkeep[p*KW +: KW]   = '0;
        bus.s_axis_tlast[p]            = 1'b0;
      end
    end
  endtask

  // Queue a packet on a source; optionally record it as expected output.
  task automatic send_pkt(input int p, input int n, input logic [DW-1:0] base, input bit expect_out);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.keep = (i == n - 1) ? 4'h7 : 4'hF;
      b.last = (i == n - 1);
      b.port = p;
      src_q[p].push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0);
      for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) done = 1'b0;
    end
    if (!done) check("drain_timeout", 64'(n), 64'(budget + 1));
    repeat (3) @(negedge clk);
  endtask

  // Source driver: retire handshaken beats, present the next ones.
  initial begin
    drive_all();
    forever begin
      @(posedge clk);
      #2;
      for (int p = 0; p < NP; p++)
        if (hs_pend[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      drive_all();
    end
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    hs_pend = bus.s_axis_tvalid & bus.s_axis_tready;
    for (int p = 0; p < NP; p++) if (hs_pend[p]) hs_cnt[p]++;
    if (sb_on && held) begin
      check("stall_valid", 64'(bus.m_axis_tvalid), 64'(1));
      check("stall_data", 64'(bus.m_axis_tdata), 64'(held_data));
      check("stall_last", 64'(bus.m_axis_tlast), 64'(held_last));
    end
    if (sb_on && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(bus.m_axis_tdata), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
        check("tkeep", 64'(bus.m_axis_tkeep), 64'(e.keep));
        check("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
`ifdef AXIS_ARB_TID_EN
        check("tid", 64'(bus.m_axis_tid), 64'(e.port));
`endif
        if (gap_on && last_out_cyc >= 0)
          check("beat_spacing", 64'(cyc - last_out_cyc), prev_last ? 64'(2) : 64'(1));
        last_out_cyc = cyc;
        prev_last    = e.last;
      end
    end
    held      = bus.m_axis_tvalid & ~bus.m_axis_tready;
    held_data = bus.m_axis_tdata;
    held_last = bus.m_axis_tlast;
  end

  initial begin
    int base;
    bit ok;
    for (int p = 0; p < NP; p++) hs_cnt[p] = 0;
    bus.m_axis_tready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_valid", 64'(bus.m_axis_tvalid), 64'(0));
    check("rst_m_data", 64'(bus.m_axis_tdata), 64'(0));
    check("rst_m_keep_last", {bus.m_axis_tkeep, bus.m_axis_tlast}, 64'(0));
    check("rst_s_ready", 64'(bus.s_axis_tready), 64'(0));
    tick();
    rst_n = 1'b1;

    // 1: all four ports, 3-beat packets, round-robin order 0..3
    gap_on = 1'b1;
    last_out_cyc = -1;
    for (int p = 0; p < NP; p++) send_pkt(p, 3, DW'((p + 1) << 24), 1'b1);
    wait_drain(200);
    gap_on = 1'b0;

    // 2: port 1 requests while port 2 is mid-packet
    tick();
    base = hs_cnt[2];
    send_pkt(2, 3, 32'h0000_00A0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (hs_cnt[2] >= base + 2);
    end
    check("t2_wait", 64'(ok), 64'(1));
    tick();
    send_pkt(1, 3, 32'h0000_0B00, 1'b1);
    wait_drain(200);

    // 3: output stall pattern 1,0,0,1 during a 4-beat packet
    tick();
    send_pkt(0, 4, 32'h0000_0C00, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.m_axis_tvalid;
    end
    check("t3_wait", 64'(ok), 64'(1));
    tick();
    bus.m_axis_tready = 1'b0;
    tick();
    bus.m_axis_tready = 1'b0;
    tick();
    bus.m_axis_tready = 1'b1;
    wait_drain(200);

    // 4: lone requester, five single-beat packets
    tick();
    gap_on = 1'b1;
    last_out_cyc = -1;
    for (int k = 0; k < 5; k++) send_pkt(3, 1, DW'(32'h0000_0D00 + k * 16), 1'b1);
    wait_drain(200);
    gap_on = 1'b0;

    // 5: reset during beat 2 of port 1's packet
    tick();
    sb_on = 1'b0;
    base = hs_cnt[1];
    send_pkt(1, 4, 32'h0000_0E00, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (hs_cnt[1] >= base + 2);
    end
    check("t5_wait", 64'(ok), 64'(1));
    tick();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_valid", 64'(bus.m_axis_tvalid), 64'(0));
    check("midrst_s_ready", 64'(bus.s_axis_tready), 64'(0));
    tick();
    rst_n = 1'b1;
    sb_on = 1'b1;
    send_pkt(0, 1, 32'h0000_0F00, 1'b1);
    send_pkt(1, 1, 32'h0000_0F10, 1'b1);
    wait_drain(200);

    // 6: fresh reset, ports 1 and 3 request together -> 1 then 3
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    send_pkt(1, 3, 32'h0000_1100, 1'b1);
    send_pkt(3, 2, 32'h0000_3300, 1'b1);
    wait_drain(200);

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
